// File: rtl/dmem_256x8.sv
// dmem_256x8: 2**AW x DW single-port data memory with combinational read, synchronous write and async active-low clear.
// Define DMEM_RD_REG_EN for a registered (read-first, 1-cycle latency) read port.
module dmem_256x8 #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] data_a,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [DW-1:0] data_b,
  output logic [DW-1:0] data_out
);

  localparam int DEPTH = 2**AW;

  // Program benches read and preload this array by hierarchical name.
  logic [DW-1:0] mem_core [0:DEPTH-1];

  logic [DW-1:0] rd_word;

  assign rd_word = mem_read ? mem_core[data_a] : '0;

  // Reset clears the whole array and wins over a write at the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mem_core <= '{default: '0};
    else if (mem_write)
      mem_core[data_a] <= data_b;
  end

`ifdef DMEM_RD_REG_EN
  // Samples the pre-edge word, so a same-address write reads the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      data_out <= '0;
    else
      data_out <= rd_word;
  end
`else
  assign data_out = rd_word;
`endif

endmodule

// File: tb/tb_dmem_256x8.sv
// Scoreboard bench for dmem_256x8: a shadow memory produces expected read data.
module tb_dmem_256x8;

  logic       clk;
  logic       reset;
  logic [7:0] data_a;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] data_b;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];
  logic [7:0] exp_q [$];

  dmem_256x8 #(.DW(8), .AW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_a   (data_a),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .data_b   (data_b),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  // Write one word through the port; model follows.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    data_a = a; data_b = d; mem_write = 1'b1;
    @(posedge clk);
    #1 mem_write = 1'b0;
    model[a] = d;
  endtask

  // Drive a read, push expected, compare when the DUT presents the data.
  task automatic rd(input logic [7:0] a, input logic en, input string name);
    logic [7:0] exp;
    @(negedge clk);
    data_a = a; mem_read = en;
    exp_q.push_back(en ? model[a] : 8'h00);
`ifdef DMEM_RD_REG_EN
    @(posedge clk);
`endif
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin
      errors++;
      $display("FAIL %s: addr=%0h data_out=%0h expected=%0h", name, a, data_out, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0; data_a = 8'h00; data_b = 8'h00;
    model_clear();
    #12;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got=%0h exp=00", data_out); end
    checks++;
    if (dut.mem_core[200] !== 8'h00) begin errors++; $display("FAIL reset_word200: got=%0h exp=00", dut.mem_core[200]); end
    @(negedge clk) reset = 1'b1;
    rd(8'h05, 1'b1, "post_reset_no_x");
    // Hierarchical preload, then reset between edges clears it immediately.
    @(negedge clk);
    dut.mem_core[5] = 8'hA5;
    #1 reset = 1'b0;
    model_clear();
    data_a = 8'h05; mem_read = 1'b1;
    #1;
    checks++;
    if (dut.mem_core[5] !== 8'h00) begin errors++; $display("FAIL reset_clear_word5: got=%0h exp=00", dut.mem_core[5]); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_clear_dout: got=%0h exp=00", data_out); end
  endtask

  task automatic test_reset_blocks_write();
    // reset still low: a write across an edge must be ignored
    @(negedge clk);
    data_a = 8'h40; data_b = 8'h77; mem_write = 1'b1;
    @(posedge clk);
    #1 mem_write = 1'b0;
    checks++;
    if (dut.mem_core[64] !== 8'h00) begin errors++; $display("FAIL write_during_reset: got=%0h exp=00", dut.mem_core[64]); end
    @(negedge clk) reset = 1'b1;
    rd(8'h40, 1'b1, "write_during_reset_rd");
  endtask

  task automatic test_write_read();
    wr(8'h02, 8'h3C);
    rd(8'h02, 1'b1, "wr_rd_addr2");
    rd(8'h03, 1'b1, "untouched_addr3");
  endtask

  task automatic test_read_gate();
    wr(8'h07, 8'hFF);
    rd(8'h07, 1'b0, "rd_gate_off");
    rd(8'h07, 1'b1, "rd_gate_on");
    // write with read disabled still lands
    @(negedge clk);
    data_a = 8'h08; data_b = 8'h66; mem_write = 1'b1; mem_read = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL wr_rd_off_dout: got=%0h exp=00", data_out); end
    @(posedge clk);
    #1 mem_write = 1'b0;
    model[8] = 8'h66;
    rd(8'h08, 1'b1, "wr_rd_off_landed");
  endtask

  task automatic test_same_addr();
    logic [7:0] exp;
    wr(8'h09, 8'h11);
    @(negedge clk);
    data_a = 8'h09; data_b = 8'h22; mem_read = 1'b1; mem_write = 1'b1;
`ifdef DMEM_RD_REG_EN
    exp_q.push_back(8'h11);
    @(posedge clk);
    #1 mem_write = 1'b0;
    model[9] = 8'h22;
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL rdw_edge_old: got=%0h exp=%0h", data_out, exp); end
    exp_q.push_back(8'h22);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL rdw_next_new: got=%0h exp=%0h", data_out, exp); end
`else
    exp_q.push_back(8'h11);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL rdw_before_edge: got=%0h exp=%0h", data_out, exp); end
    exp_q.push_back(8'h22);
    @(posedge clk);
    #1 mem_write = 1'b0;
    model[9] = 8'h22;
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin errors++; $display("FAIL rdw_after_edge: got=%0h exp=%0h", data_out, exp); end
`endif
  endtask

  task automatic test_extremes();
    wr(8'hFF, 8'h5A);
    wr(8'h00, 8'hC3);
    rd(8'hFF, 1'b1, "addr_ff");
    rd(8'h00, 1'b1, "addr_00");
    rd(8'h7F, 1'b1, "addr_7f_no_alias");
  endtask

  task automatic test_hier();
    @(negedge clk);
    dut.mem_core[1] = 8'h12;
    dut.mem_core[0] = 8'h34;
    model[1] = 8'h12; model[0] = 8'h34;
    rd(8'h00, 1'b1, "hier_rd0");
    rd(8'h01, 1'b1, "hier_rd1");
    wr(8'h03, 8'hAB);
    wr(8'h02, 8'hCD);
    #1;
    checks++;
    if ({dut.mem_core[3], dut.mem_core[2]} !== 16'hABCD) begin
      errors++;
      $display("FAIL hier_result: got=%0h exp=abcd", {dut.mem_core[3], dut.mem_core[2]});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) wr(a, 8'($urandom));
      else rd(a, 1'($urandom_range(0, 1)), "random_rd");
    end
    for (int i = 0; i < 8; i++) rd(8'(i * 37), 1'b1, "sweep_rd");
  endtask

  task automatic test_reset_wins();
    // reset asserted while a write is pending at the same edge
    @(negedge clk);
    data_a = 8'h02; data_b = 8'hEE; mem_write = 1'b1;
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1 mem_write = 1'b0;
    @(negedge clk) reset = 1'b1;
    rd(8'h02, 1'b1, "reset_wins_addr2");
    rd(8'hFF, 1'b1, "reset_wins_addrff");
  endtask

  initial begin
    test_reset();
    test_reset_blocks_write();
    test_write_read();
    test_read_gate();
    test_same_addr();
    test_extremes();
    test_hier();
    test_back_to_back();
    test_reset_wins();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_256x8.md
Name: dmem_256x8

Overview:
- Single-port byte-wide data memory used by the program datapaths: 256 x 8 bits, combinational read, synchronous write.
- Storage array is named mem_core so program benches can preload operands and check results hierarchically; e.g. operand bytes go in mem_core[1:0] and result bytes are read from mem_core[3:2].
- It is the design's only data store; the instruction memory is separate.

Parameters:
- DW, 8, data width in bits of each word and of the data ports.
- AW, 8, address width; depth = 2**AW words.

Ports:
- clk  input  1  single clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears every word of mem_core.
- data_a  input  AW  word address (pointer) for both read and write.
- mem_read  input  1  read enable; may be tied high.
- mem_write  input  1  write enable, sampled at posedge clk.
- data_b  input  DW  write data.
- data_out  output  DW  read data.

Behaviour:
- Storage: unpacked array mem_core[0 : 2**AW-1], each word [DW-1:0].
  - The name and indexing are fixed; benches access it hierarchically.
  - Word 0 is the low byte of multi-byte operands (little-endian convention).
- Reset:
  - Taking reset low immediately (no clock needed) forces every mem_core word to 0.
  - data_out therefore reads 0 while reset is low, or 0 anyway when mem_read=0.
  - While reset is low, writes are ignored.
  - Reset released between clock edges: the first write can occur at the next posedge.
- Read (default build): purely combinational.
  - data_out = mem_read ? mem_core[data_a] : {DW{1'b0}}.
  - Zero cycles of latency; data_out follows data_a and memory contents within the same cycle.
- Write:
  - At posedge clk, if reset is high and mem_write=1, mem_core[data_a] <= data_b.
  - Only the addressed word changes; all other words hold.
- Read and write at the same address in the same cycle (default build):
  - data_out shows the old value before the edge and the new value after it.
  - There is no write-to-read bypass.
- mem_read=0 and mem_write=1: the write still occurs; data_out = 0.
- Address wrap: data_a is exactly AW bits, so every address is valid; no out-of-range case exists.
- Reset asserted mid-sequence: reset wins over any pending write at the same edge; contents are lost, including hierarchically preloaded values.
- No X on data_out after reset has been applied once.

Optional Feature:
- Macro: DMEM_RD_REG_EN.
- Defined: read is registered, giving 1-cycle latency.
  - At posedge clk, data_out <= mem_read ? mem_core[data_a] : 0.
  - Read-during-write to the same address returns the OLD word (read-first).
  - The data_out register resets asynchronously to 0 with reset.
- Not defined: the combinational read described above; no extra register exists.

Test Plan:
- Reset clear: preload mem_core[5]=8'hA5, then drive reset low without a clock edge -> mem_core[5]=0 immediately; data_a=5, mem_read=1 -> data_out=8'h00.
- Write/read: after reset high, write 8'h3C to addr 8'h02 at one edge, then set data_a=2, mem_read=1 -> data_out=8'h3C combinationally (or one cycle later with DMEM_RD_REG_EN). Address 8'h03 still reads 8'h00.
- Read enable gating: mem_core[7]=8'hFF, data_a=7, mem_read=0 -> data_out=8'h00; raise mem_read=1 -> 8'hFF.
- Same-address read/write: mem_core[9]=8'h11, then write 8'h22 to addr 9 with mem_read=1 -> data_out=8'h11 before the edge and 8'h22 after. With DMEM_RD_REG_EN the registered output is 8'h11 for that edge.
- Address extremes: write 8'h5A to addr 8'hFF and 8'hC3 to addr 8'h00 -> both read back correctly, with no aliasing between them.
- Hierarchical access: bench sets mem_core[1]=8'h12 and mem_core[0]=8'h34 -> reading addrs 0 and 1 returns 8'h34 and 8'h12. The DUT writes 8'hAB to addr 3 and 8'hCD to addr 2 -> {mem_core[3],mem_core[2]} = 16'hABCD.
